// File: rtl/tmul_lanes.sv
// Multi-lane temporal-coded stochastic multiplier: operand A is a thermometer
// run of A cycles, each lane's B is a bit-reversed-counter rate stream.
module tmul_lanes #(
    parameter int INWD  = 8,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INWD-1:0]         iA,
    input  logic [LANES*INWD-1:0]   iB,
    input  logic                    load,
    output logic [LANES-1:0]        oC,
    output logic [LANES*INWD-1:0]   oCnt,
    output logic                    busy,
    output logic                    stop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [INWD-1:0] a_r;
    logic [INWD-1:0] t;
    logic [INWD-1:0] t_rev;
    logic            run;
    logic            last;

    assign run  = (state == S_RUN);
    // a_r is never zero in RUN, so a_r-1 cannot underflow here.
    assign last = run && (t == a_r - 1'b1);
    assign busy = run;
    assign stop = (state == S_DONE);

    for (genvar gi = 0; gi < INWD; gi++) begin : g_rev
        assign t_rev[gi] = t[INWD-1-gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_r   <= '0;
            t     <= '0;
        end else if (load) begin
            a_r   <= iA;
            t     <= '0;
            state <= (iA != '0) ? S_RUN : S_DONE;
        end else if (run) begin
            t <= t + 1'b1;
            if (last) begin
                state <= S_DONE;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [INWD-1:0] b_r;
        logic [INWD-1:0] cnt;
        logic            oc_bit;

        // Gated by RUN so IDLE/DONE present an all-zero stream.
        assign oc_bit = run && (t_rev < b_r);
        assign oC[gi] = oc_bit;
        assign oCnt[gi*INWD +: INWD] = cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b_r <= '0;
                cnt <= '0;
            end else if (load) begin
                b_r <= iB[gi*INWD +: INWD];
                cnt <= '0;
            end else if (run) begin
                cnt <= cnt + {{(INWD-1){1'b0}}, oc_bit};
            end
        end
    end

endmodule

// File: tb/tb_tmul_lanes.sv
// Directed-vector bench for tmul_lanes (INWD=8, LANES=4) with hand-computed results.
module tb_tmul_lanes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  iA = '0;
    logic [31:0] iB = '0;
    logic        load = 1'b0;
    logic [3:0]  oC;
    logic [31:0] oCnt;
    logic        busy;
    logic        stop;

    int errors = 0;
    int checks = 0;

    tmul_lanes #(.INWD(8), .LANES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .iA   (iA),
        .iB   (iB),
        .load (load),
        .oC   (oC),
        .oCnt (oCnt),
        .busy (busy),
        .stop (stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Returns at the falling edge right after the sampling edge E0.
    task automatic do_load(input logic [7:0] a, input logic [31:0] b);
        @(negedge clk);
        iA = a;
        iB = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic watch(input string tag, input logic [7:0] a, input logic [31:0] exp_cnt);
        int n;
        int busy_n;
        int ones[4];
        n = 1;
        busy_n = 0;
        for (int k = 0; k < 4; k++) ones[k] = 0;
        while (!stop && n < 400) begin
            if (busy) busy_n++;
            for (int k = 0; k < 4; k++) ones[k] += int'(oC[k]);
            @(negedge clk);
            n++;
        end
        check({tag, " stop_seen"}, 32'(stop), 32'd1);
        check({tag, " latency"}, n, 32'(a) + 32'd1);
        check({tag, " busy_cycles"}, busy_n, 32'(a));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s oC_ones[%0d]", tag, k), ones[k], 32'(exp_cnt[k*8 +: 8]));
            check($sformatf("%s oCnt[%0d]", tag, k), 32'(oCnt[k*8 +: 8]), 32'(exp_cnt[k*8 +: 8]));
        end
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " oC_done"}, 32'(oC), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " stop_hold"}, 32'(stop), 32'd1);
        check({tag, " oCnt_hold"}, oCnt, exp_cnt);
        $display("vector %s: A=%0d oCnt=%h latency=%0d", tag, a, oCnt, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset stop", 32'(stop), 32'd0);
        check("reset oC", 32'(oC), 32'd0);
        check("reset oCnt", oCnt, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle stop", 32'(stop), 32'd0);

        do_load(8'd128, pack4(8'd128, 8'd0, 8'd255, 8'd64));
        check("v1 oC_first", 32'(oC), 32'b1101);
        watch("v1", 8'd128, pack4(8'd64, 8'd0, 8'd128, 8'd32));

        do_load(8'd64, pack4(8'd192, 8'd192, 8'd1, 8'd100));
        check("v2 oC_first", 32'(oC), 32'b1111);
        watch("v2", 8'd64, pack4(8'd48, 8'd48, 8'd1, 8'd25));

        do_load(8'd0, pack4(8'd255, 8'd255, 8'd255, 8'd255));
        check("v3 oC_first", 32'(oC), 32'd0);
        watch("v3", 8'd0, 32'd0);

        do_load(8'd255, pack4(8'd255, 8'd255, 8'd255, 8'd255));
        check("v4 oC_first", 32'(oC), 32'b1111);
        watch("v4", 8'd255, pack4(8'd255, 8'd255, 8'd255, 8'd255));

        // Reload during a run: t=10 after ten more edges; B=128 gives 5 ones by then.
        do_load(8'd128, pack4(8'd128, 8'd128, 8'd128, 8'd128));
        repeat (10) @(negedge clk);
        check("v5 partial_cnt", 32'(oCnt[7:0]), 32'd5);
        check("v5 busy_mid", 32'(busy), 32'd1);
        do_load(8'd64, pack4(8'd192, 8'd192, 8'd192, 8'd192));
        check("v5 cnt_restart", oCnt, 32'd0);
        watch("v5", 8'd64, pack4(8'd48, 8'd48, 8'd48, 8'd48));

        // Asynchronous reset at t=50, away from any clock edge.
        do_load(8'd128, pack4(8'd128, 8'd255, 8'd64, 8'd200));
        repeat (50) @(negedge clk);
        check("v6 busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("v6 rst busy", 32'(busy), 32'd0);
        check("v6 rst stop", 32'(stop), 32'd0);
        check("v6 rst oC", 32'(oC), 32'd0);
        check("v6 rst oCnt", oCnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("v6 idle busy", 32'(busy), 32'd0);
        check("v6 idle stop", 32'(stop), 32'd0);
        check("v6 idle oCnt", oCnt, 32'd0);
        $display("vector v6: async reset mid-run, oCnt=%h", oCnt);

        do_load(8'd64, pack4(8'd192, 8'd192, 8'd1, 8'd100));
        watch("v7", 8'd64, pack4(8'd48, 8'd48, 8'd1, 8'd25));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
